axis_rotate_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares one `axis_rotate` byte-rotation engine between `NUM_PORTS` AXI-Stream requesters. It sits directly upstream of `axis_rotate`: it selects one source and locks to it until that packet's `tlast` beat completes. It normalises each beat's rotate command in `tuser` and forwards the beats through a one-deep output register. A source-index sideband lets downstream logic steer results back to the requester.

---
 rtl/axis_rotate_pkg.sv | 29 ++
 rtl/rr_priority_select.sv | 34 +++
 rtl/axis_rotate_arbiter.sv | 106 ++++++++++
 tb/tb_axis_rotate_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_rotate_pkg.sv
// Shared definitions for the axis_rotate front end.
//   arb_state_e : arbiter FSM states (IDLE waits for a request, LOCK owns a packet)
//   dir_bit     : index of the rotate-direction bit inside tuser
//   amt_mask    : mask that keeps the rotation amount below the bytes-per-beat count
//   norm_tuser  : direction bit kept, amount reduced modulo DATA_WIDTH/8
package axis_rotate_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  function automatic int dir_bit(input int tuser_w);
    return tuser_w - 1;
  endfunction

  // DATA_WIDTH/8 is a power of two, so "mod bytes" is a mask of the low bits.
  // The direction bit is excluded even if the byte count is unusually large.
  function automatic logic [31:0] amt_mask(input int data_w, input int tuser_w);
    return 32'((data_w / 8) - 1) & ((32'd1 << dir_bit(tuser_w)) - 32'd1);
  endfunction

  function automatic logic [31:0] norm_tuser(input logic [31:0] tuser,
                                             input int          data_w,
                                             input int          tuser_w);
    return (tuser & (32'd1 << dir_bit(tuser_w))) | (tuser & amt_mask(data_w, tuser_w));
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin picker.
//   req     : request vector, one bit per port
//   ptr     : highest-priority port this round
//   gnt     : one-hot grant (all zero when nothing requests)
//   gnt_idx : binary index of the granted port
module rr_priority_select #(
  parameter int NUM_PORTS = 4,
  parameter int ID_WIDTH  = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [ID_WIDTH-1:0]  ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [ID_WIDTH-1:0]  gnt_idx
);

  logic [ID_WIDTH-1:0] idx;

  // Walk from the farthest candidate back toward ptr so the closest
  // requester at or after ptr is the last one to overwrite the result.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = ID_WIDTH'((int'(ptr) + k) % NUM_PORTS);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/axis_rotate_arbiter.sv
// Packet-granular round-robin arbiter in front of one axis_rotate engine.
// Locks onto one source until its tlast beat is accepted, normalises the
// rotate command and forwards beats through a one-deep output register.
//   aclk, areset       : clock, async active-high reset
//   s_axis_*           : NUM_PORTS flattened AXI-Stream slave ports
//   m_axis_t{data,user,valid,last,id}, m_axis_tready : master port to the engine
//   busy               : high while a packet is locked
module axis_rotate_arbiter
  import axis_rotate_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int TUSER_WIDTH = 8,
  parameter int ID_WIDTH    = 2
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_PORTS*TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]             s_axis_tlast,
  output logic [NUM_PORTS-1:0]             s_axis_tready,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [TUSER_WIDTH-1:0]           m_axis_tuser,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic [ID_WIDTH-1:0]              m_axis_tid,
  output logic                             busy
);

  arb_state_e state, state_nx;

  logic [ID_WIDTH-1:0]    grant, rr_ptr, pick_idx, grant_inc;
  logic [NUM_PORTS-1:0]   pick_oh;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [TUSER_WIDTH-1:0] sel_tuser;
  logic                   sel_valid, sel_last;
  logic                   out_free, src_hs;

  rr_priority_select #(
    .NUM_PORTS (NUM_PORTS),
    .ID_WIDTH  (ID_WIDTH)
  ) u_pick (
    .req     (s_axis_tvalid),
    .ptr     (rr_ptr),
    .gnt     (pick_oh),
    .gnt_idx (pick_idx)
  );

  // Source mux driven by the registered grant.
  assign sel_data  = s_axis_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_tuser = s_axis_tuser[int'(grant)*TUSER_WIDTH +: TUSER_WIDTH];
  assign sel_valid = s_axis_tvalid[grant];
  assign sel_last  = s_axis_tlast[grant];

  // Output register can take a beat when empty or draining this cycle.
  assign out_free  = !m_axis_tvalid || m_axis_tready;
  assign src_hs    = (state == LOCK) && sel_valid && out_free;
  assign grant_inc = (grant == ID_WIDTH'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
  assign busy      = (state == LOCK);

  always_comb begin
    state_nx      = state;
    s_axis_tready = '0;
    unique case (state)
      IDLE: if (|pick_oh) state_nx = LOCK;
      LOCK: begin
        s_axis_tready[grant] = out_free;
        if (src_hs && sel_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && |pick_oh) grant <= pick_idx;
      if (src_hs && sel_last)        rr_ptr <= grant_inc;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
    end else if (src_hs) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= sel_data;
      m_axis_tuser  <= TUSER_WIDTH'(norm_tuser(32'(sel_tuser), DATA_WIDTH, TUSER_WIDTH));
      m_axis_tlast  <= sel_last;
      m_axis_tid    <= grant;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_rotate_arbiter.sv
// Scoreboard bench for axis_rotate_arbiter. Per-port packet queues feed
// AXI-Stream drivers; a reference model orders whole packets round-robin
// and fills expected input/output queues that a negedge monitor consumes.
module tb_axis_rotate_arbiter;
  localparam int NP = 4, DW = 32, TW = 8, IW = 2;

  logic aclk = 1'b0;
  logic areset;
  logic [NP*DW-1:0] s_axis_tdata;
  logic [NP*TW-1:0] s_axis_tuser;
  logic [NP-1:0]    s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [DW-1:0]    m_axis_tdata;
  logic [TW-1:0]    m_axis_tuser;
  logic             m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [IW-1:0]    m_axis_tid;
  logic             busy;

  always #5 aclk = ~aclk;

  axis_rotate_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .TUSER_WIDTH(TW), .ID_WIDTH(IW)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
    .busy(busy)
  );

  typedef struct { logic [DW-1:0] data; logic [TW-1:0] tuser; logic last; } beat_t;
  typedef struct { logic [DW-1:0] data; logic [TW-1:0] tuser; logic last; int id; } obeat_t;
  typedef struct { int port; logic [DW-1:0] data; } ibeat_t;

  beat_t  src_q[NP][$];
  beat_t  mdl_q[NP][$];
  int     dly[NP];
  obeat_t exp_out[$];
  ibeat_t exp_in[$];

  int   n_chk = 0, n_fail = 0;
  int   mdl_ptr = 0;
  int   mode = 0;
  int   bp_hold = 0;
  logic gap_chk = 1'b0;
  int   phase_id = 0;
  logic [NP-1:0] hs_seen = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Rotate command as the engine should see it: direction kept, amount
  // taken modulo the number of bytes in a beat.
  function automatic logic [TW-1:0] norm(input logic [TW-1:0] t);
    logic [TW-2:0] amt;
    amt = t[TW-2:0] % (TW-1)'(DW / 8);
    return {t[TW-1], amt};
  endfunction

  task automatic add_beat(input int p, input logic [DW-1:0] d, input logic [TW-1:0] tu, input logic last);
    beat_t b;
    b = '{d, tu, last};
    src_q[p].push_back(b);
    mdl_q[p].push_back(b);
  endtask

  task automatic add_rand_pkt(input int p, input int n);
    for (int i = 0; i < n; i++) add_beat(p, $urandom, TW'($urandom), i == n - 1);
  endtask

  // Whole-packet round-robin: every port with packets left is requesting at
  // each decision, except that ports with a start delay miss the first one.
  task automatic run_model();
    beat_t b;
    int    pk;
    int    q;
    bit    first;
    first = 1'b1;
    forever begin
      pk = -1;
      for (int k = 0; k < NP; k++) begin
        q = (mdl_ptr + k) % NP;
        if (pk < 0 && mdl_q[q].size() > 0 && (!first || dly[q] == 0)) pk = q;
      end
      if (pk < 0) begin
        if (!first) break;
        first = 1'b0;
        continue;
      end
      first = 1'b0;
      do begin
        b = mdl_q[pk].pop_front();
        exp_out.push_back('{b.data, norm(b.tuser), b.last, pk});
        exp_in.push_back('{pk, b.data});
      end while (!b.last);
      mdl_ptr = (pk + 1) % NP;
    end
  endtask

  task automatic flush_all();
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      mdl_q[p].delete();
    end
    exp_out.delete();
    exp_in.delete();
  endtask

  task automatic start_phase(input logic g, input int m);
    @(negedge aclk);
    #1;
    phase_id++;
    gap_chk = g;
    mode = m;
  endtask

  task automatic wait_done(input string name, input int budget);
    int c;
    c = 0;
    while ((exp_out.size() != 0 || exp_in.size() != 0) && c < budget) begin
      @(negedge aclk);
      c++;
    end
    n_chk++;
    if (c >= budget) begin
      n_fail++;
      $display("FAIL %s: timeout with %0d output beats outstanding", name, exp_out.size());
      flush_all();
    end
    repeat (3) @(negedge aclk);
  endtask

  // Source and sink drivers: act just after each rising edge.
  always @(posedge aclk) begin
    #1;
    if (areset) begin
      s_axis_tvalid = '0;
      m_axis_tready = 1'b1;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (hs_seen[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
        if (dly[p] > 0) begin
          dly[p]--;
          s_axis_tvalid[p] = 1'b0;
        end else if (src_q[p].size() > 0) begin
          s_axis_tdata[p*DW +: DW] = src_q[p][0].data;
          s_axis_tuser[p*TW +: TW] = src_q[p][0].tuser;
          s_axis_tlast[p]          = src_q[p][0].last;
          s_axis_tvalid[p]         = 1'b1;
        end else begin
          s_axis_tvalid[p] = 1'b0;
        end
      end
      if (bp_hold > 0) begin
        m_axis_tready = 1'b0;
        bp_hold--;
      end else if (mode == 1) m_axis_tready = ($urandom_range(0, 3) != 0);
      else m_axis_tready = 1'b1;
    end
  end

  // Monitor: samples on the falling edge, away from the active edge.
  logic          prev_hold = 1'b0;
  logic [DW-1:0] h_data;
  logic [TW-1:0] h_tuser;
  logic          h_last;
  logic [IW-1:0] h_id;
  int            cyc = 0, last_hs = -1, seen_phase = 0;
  logic          last_was_tlast = 1'b0;
  ibeat_t        ie;
  obeat_t        oe;

  always @(negedge aclk) begin
    cyc++;
    if (phase_id != seen_phase) begin
      seen_phase = phase_id;
      last_hs = -1;
    end
    hs_seen = s_axis_tvalid & s_axis_tready;
    if (areset) begin
      prev_hold = 1'b0;
    end else begin
      check("tready_onehot", 64'($countones(s_axis_tready) <= 1), 64'd1);
      if (s_axis_tready != '0) check("busy_while_ready", 64'(busy), 64'd1);
      for (int p = 0; p < NP; p++) begin
        if (hs_seen[p]) begin
          if (exp_in.size() == 0) fail_now("unexpected_source_handshake");
          else begin
            ie = exp_in.pop_front();
            check("src_port", 64'(p), 64'(ie.port));
            check("src_data", 64'(s_axis_tdata[p*DW +: DW]), 64'(ie.data));
          end
        end
      end
      if (prev_hold) begin
        check("hold_valid", 64'(m_axis_tvalid), 64'd1);
        check("hold_data", 64'(m_axis_tdata), 64'(h_data));
        check("hold_tuser", 64'(m_axis_tuser), 64'(h_tuser));
        check("hold_last", 64'(m_axis_tlast), 64'(h_last));
        check("hold_tid", 64'(m_axis_tid), 64'(h_id));
      end
      if (m_axis_tvalid && !m_axis_tready) check("bp_src_tready", 64'(s_axis_tready), 64'd0);
      prev_hold = m_axis_tvalid && !m_axis_tready;
      h_data = m_axis_tdata; h_tuser = m_axis_tuser; h_last = m_axis_tlast; h_id = m_axis_tid;
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_out.size() == 0) fail_now("unexpected_output_beat");
        else begin
          oe = exp_out.pop_front();
          check("out_data", 64'(m_axis_tdata), 64'(oe.data));
          check("out_tuser", 64'(m_axis_tuser), 64'(oe.tuser));
          check("out_last", 64'(m_axis_tlast), 64'(oe.last));
          check("out_tid", 64'(m_axis_tid), 64'(oe.id));
        end
        // Back-to-back inside a packet, one idle cycle between packets.
        if (gap_chk && last_hs >= 0) check("beat_spacing", 64'(cyc - last_hs), last_was_tlast ? 64'd2 : 64'd1);
        last_hs = cyc;
        last_was_tlast = m_axis_tlast;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    check({tag, "_m_tlast"}, 64'(m_axis_tlast), 64'd0);
    check({tag, "_m_tdata"}, 64'(m_axis_tdata), 64'd0);
    check({tag, "_m_tuser"}, 64'(m_axis_tuser), 64'd0);
    check({tag, "_m_tid"}, 64'(m_axis_tid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_s_tready"}, 64'(s_axis_tready), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, c;
    areset = 1'b1;
    s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tdata = '0; s_axis_tuser = '0;
    m_axis_tready = 1'b1;
    for (int p = 0; p < NP; p++) dly[p] = 0;
    repeat (3) @(posedge aclk);
    #2;
    check_reset_outputs("reset");
    @(posedge aclk);
    #3 areset = 1'b0;

    // Round-robin: every port holds two 2-beat packets.
    start_phase(1'b1, 0);
    for (int p = 0; p < NP; p++) begin
      add_rand_pkt(p, 2);
      add_rand_pkt(p, 2);
    end
    run_model();
    wait_done("round_robin", 300);

    // Single source on port 0 with first-beat latency.
    start_phase(1'b1, 0);
    add_beat(0, 32'h12345678, 8'h02, 1'b0);
    add_beat(0, 32'hAABBCCDD, 8'h02, 1'b0);
    add_beat(0, 32'h01020304, 8'h02, 1'b1);
    run_model();
    lat = 0;
    while (lat < 20) begin
      @(negedge aclk);
      if (m_axis_tvalid) break;
      lat++;
    end
    check("first_beat_latency", 64'(lat), 64'd2);
    wait_done("single_source", 100);

    // Normalisation on port 3.
    start_phase(1'b1, 0);
    add_beat(3, 32'hCAFEF00D, 8'h86, 1'b0);
    add_beat(3, 32'h0BADBEEF, 8'h05, 1'b1);
    run_model();
    wait_done("normalise", 100);

    // Lock: port 0 arrives while port 1 is mid-packet.
    start_phase(1'b1, 0);
    dly[0] = 2;
    add_rand_pkt(1, 4);
    add_rand_pkt(0, 2);
    run_model();
    wait_done("lock_p0", 200);

    // Lock: ports 0 and 2 arrive while port 1 is mid-packet; port 2 wins next.
    start_phase(1'b1, 0);
    dly[0] = 2;
    dly[2] = 2;
    add_rand_pkt(1, 4);
    add_rand_pkt(0, 2);
    add_rand_pkt(2, 2);
    run_model();
    wait_done("lock_p2", 200);

    // Backpressure: 5 stalled cycles in the middle of a 6-beat packet.
    start_phase(1'b0, 0);
    add_rand_pkt(2, 6);
    run_model();
    c = 0;
    while (exp_out.size() > 4 && c < 50) begin
      @(negedge aclk);
      c++;
    end
    bp_hold = 5;
    wait_done("backpressure", 200);

    // Randomised traffic with random sink stalls.
    for (int r = 0; r < 8; r++) begin
      start_phase(1'b0, 1);
      for (int p = 0; p < NP; p++) begin
        int npk;
        npk = $urandom_range(0, 3);
        for (int k = 0; k < npk; k++) add_rand_pkt(p, $urandom_range(1, 4));
      end
      run_model();
      wait_done("random", 2000);
    end

    // Reset while beat 2 of a 4-beat packet is in flight.
    start_phase(1'b0, 0);
    add_rand_pkt(2, 4);
    run_model();
    c = 0;
    while (exp_out.size() > 3 && c < 50) begin
      @(negedge aclk);
      c++;
    end
    @(posedge aclk);
    #3 areset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    flush_all();
    mdl_ptr = 0;
    repeat (2) @(posedge aclk);
    #3 areset = 1'b0;

    // Arbitration restarts from port 0.
    start_phase(1'b1, 0);
    for (int p = NP - 1; p >= 0; p--) add_rand_pkt(p, 2);
    run_model();
    wait_done("after_reset", 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
